// File: rtl/sdram_inbuf_loader_pkg.sv
// Shared definitions for the SDRAM input-buffer loader: FSM state encoding,
// Avalon burstcount width and the burst-size helper.
package sdram_inbuf_loader_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ISSUE     = 2'd1,
        ST_WAIT_DATA = 2'd2,
        ST_FINISH    = 2'd3
    } state_t;

    localparam int BURSTCOUNT_W = 7;

    // Beats for the next burst: the smaller of the words still owed and the burst cap.
    function automatic logic [BURSTCOUNT_W-1:0] min_burst(input logic [31:0] remaining,
                                                          input logic [31:0] burst_len);
        logic [31:0] w_m;
        w_m = (remaining < burst_len) ? remaining : burst_len;
        return w_m[BURSTCOUNT_W-1:0];
    endfunction

endpackage

// File: rtl/sdram_inbuf_loader_addr_gen.sv
// Address generator for the input-buffer loader: tracks the current SDRAM word
// address, the words still to be requested and the size of the next burst.
module inbuf_loader_addr_gen
    import sdram_inbuf_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int BUF_AW    = 10,
    parameter int BURST_LEN = 16
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    i_load,
    input  logic [ADDR_W-1:0]       i_base,
    input  logic [BUF_AW:0]         i_num,
    input  logic                    i_advance,
    output logic [ADDR_W-1:0]       o_addr,
    output logic [BUF_AW:0]         o_remaining,
    output logic [BURSTCOUNT_W-1:0] o_burst
);
    localparam int              CNT_W     = BUF_AW + 1;
    localparam logic [CNT_W-1:0] MAX_WORDS = CNT_W'(1) << BUF_AW;

    logic [ADDR_W-1:0]       r_addr;
    logic [CNT_W-1:0]        r_remaining;
    logic [BURSTCOUNT_W-1:0] r_burst;
    logic [CNT_W-1:0]        w_num_clamped;
    logic [CNT_W-1:0]        w_rem_next;

    // Requests larger than the buffer are clamped to the buffer depth.
    assign w_num_clamped = (i_num > MAX_WORDS) ? MAX_WORDS : i_num;
    assign w_rem_next    = r_remaining - CNT_W'(r_burst);

    // Load on an accepted start; step past each accepted burst (address wraps naturally).
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_addr      <= '0;
            r_remaining <= '0;
            r_burst     <= '0;
        end else if (i_load) begin
            r_addr      <= i_base;
            r_remaining <= w_num_clamped;
            r_burst     <= min_burst(32'(w_num_clamped), 32'(BURST_LEN));
        end else if (i_advance) begin
            r_addr      <= r_addr + ADDR_W'(r_burst);
            r_remaining <= w_rem_next;
            r_burst     <= min_burst(32'(w_rem_next), 32'(BURST_LEN));
        end
    end

    assign o_addr      = r_addr;
    assign o_remaining = r_remaining;
    assign o_burst     = r_burst;

endmodule

// File: rtl/sdram_inbuf_loader.sv
// SDRAM-to-input-buffer loader: issues Avalon-MM read bursts (one outstanding at a
// time) and streams the returned beats into the input buffer from address 0.
// Optional macro INBUF_LOADER_STATS_EN adds stall_cycles / xfer_cycles counters.
module sdram_inbuf_loader
    import sdram_inbuf_loader_pkg::*;
#(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 256,
    parameter int BURST_LEN = 16,
    parameter int BUF_AW    = 10
)(
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic [BUF_AW:0]         num_words,
    output logic [ADDR_W-1:0]       avm_address,
    output logic                    avm_read,
    output logic [BURSTCOUNT_W-1:0] avm_burstcount,
    input  logic                    avm_waitrequest,
    input  logic [DATA_W-1:0]       avm_readdata,
    input  logic                    avm_readdatavalid,
    output logic                    buf_wr_en,
    output logic [BUF_AW-1:0]       buf_wr_addr,
    output logic [DATA_W-1:0]       buf_wr_data,
    output logic                    busy,
    output logic                    done
`ifdef INBUF_LOADER_STATS_EN
    ,
    output logic [31:0]             stall_cycles,
    output logic [31:0]             xfer_cycles
`endif
);
    state_t                  r_state;
    logic                    r_avm_read;
    logic                    r_busy;
    logic                    r_done;
    logic [BURSTCOUNT_W-1:0] r_beats_left;
    logic [BUF_AW-1:0]       r_wr_ptr;
    logic                    r_buf_wr_en;
    logic [BUF_AW-1:0]       r_buf_wr_addr;
    logic [DATA_W-1:0]       r_buf_wr_data;

    logic                    w_accept;
    logic                    w_load;
    logic                    w_advance;
    logic [ADDR_W-1:0]       w_addr;
    logic [BUF_AW:0]         w_remaining;
    logic [BURSTCOUNT_W-1:0] w_burst;

    assign w_accept  = (r_state == ST_IDLE) && start;
    assign w_load    = w_accept && (num_words != '0);
    assign w_advance = (r_state == ST_ISSUE) && !avm_waitrequest;

    inbuf_loader_addr_gen #(
        .ADDR_W    (ADDR_W),
        .BUF_AW    (BUF_AW),
        .BURST_LEN (BURST_LEN)
    ) u_addr_gen (
        .clk         (clk),
        .reset_n     (reset_n),
        .i_load      (w_load),
        .i_base      (base_addr),
        .i_num       (num_words),
        .i_advance   (w_advance),
        .o_addr      (w_addr),
        .o_remaining (w_remaining),
        .o_burst     (w_burst)
    );

    // Transfer FSM with beat counting and the registered bus / buffer outputs.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_IDLE;
            r_avm_read    <= 1'b0;
            r_busy        <= 1'b0;
            r_done        <= 1'b0;
            r_beats_left  <= '0;
            r_wr_ptr      <= '0;
            r_buf_wr_en   <= 1'b0;
            r_buf_wr_addr <= '0;
            r_buf_wr_data <= '0;
        end else begin
            r_done      <= 1'b0;
            r_buf_wr_en <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        if (num_words != '0) begin
                            r_state    <= ST_ISSUE;
                            r_avm_read <= 1'b1;
                            r_busy     <= 1'b1;
                            r_wr_ptr   <= '0;
                        end else begin
                            r_state <= ST_FINISH;
                            r_done  <= 1'b1;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (!avm_waitrequest) begin
                        r_avm_read   <= 1'b0;
                        r_beats_left <= w_burst;
                        r_state      <= ST_WAIT_DATA;
                    end
                end
                ST_WAIT_DATA: begin
                    if (avm_readdatavalid) begin
                        r_buf_wr_en   <= 1'b1;
                        r_buf_wr_addr <= r_wr_ptr;
                        r_buf_wr_data <= avm_readdata;
                        r_wr_ptr      <= r_wr_ptr + BUF_AW'(1);
                        r_beats_left  <= r_beats_left - BURSTCOUNT_W'(1);
                        if (r_beats_left == BURSTCOUNT_W'(1)) begin
                            if (w_remaining != '0) begin
                                r_state    <= ST_ISSUE;
                                r_avm_read <= 1'b1;
                            end else begin
                                r_state <= ST_FINISH;
                                r_done  <= 1'b1;
                                r_busy  <= 1'b0;
                            end
                        end
                    end
                end
                ST_FINISH: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign avm_address    = w_addr;
    assign avm_burstcount = w_burst;
    assign avm_read       = r_avm_read;
    assign buf_wr_en      = r_buf_wr_en;
    assign buf_wr_addr    = r_buf_wr_addr;
    assign buf_wr_data    = r_buf_wr_data;
    assign busy           = r_busy;
    assign done           = r_done;

`ifdef INBUF_LOADER_STATS_EN
    logic [31:0] r_stall_cycles;
    logic [31:0] r_xfer_cycles;

    // Saturating stall / busy-cycle counters, cleared on each accepted start.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_stall_cycles <= '0;
            r_xfer_cycles  <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
            r_xfer_cycles  <= '0;
        end else begin
            if ((r_state == ST_ISSUE) && avm_waitrequest && (r_stall_cycles != '1))
                r_stall_cycles <= r_stall_cycles + 32'd1;
            if (r_busy && (r_xfer_cycles != '1))
                r_xfer_cycles <= r_xfer_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign xfer_cycles  = r_xfer_cycles;
`endif

endmodule

// File: tb/tb_sdram_inbuf_loader.sv
// Testbench for sdram_inbuf_loader: table of transfers run against an Avalon
// slave model, with expected bursts and buffer writes kept in scoreboard queues,
// plus hand-written sequences for reset mid-burst and start during FINISH.
module tb_sdram_inbuf_loader;
    localparam int ADDR_W    = 32;
    localparam int DATA_W    = 256;
    localparam int BURST_LEN = 16;
    localparam int BUF_AW    = 10;

    logic              clk;
    logic              reset_n;
    logic              start;
    logic [ADDR_W-1:0] base_addr;
    logic [BUF_AW:0]   num_words;
    logic [ADDR_W-1:0] avm_address;
    logic              avm_read;
    logic [6:0]        avm_burstcount;
    logic              avm_waitrequest;
    logic [DATA_W-1:0] avm_readdata;
    logic              avm_readdatavalid;
    logic              buf_wr_en;
    logic [BUF_AW-1:0] buf_wr_addr;
    logic [DATA_W-1:0] buf_wr_data;
    logic              busy;
    logic              done;
`ifdef INBUF_LOADER_STATS_EN
    logic [31:0]       stall_cycles;
    logic [31:0]       xfer_cycles;
`endif

    sdram_inbuf_loader #(
        .ADDR_W    (ADDR_W),
        .DATA_W    (DATA_W),
        .BURST_LEN (BURST_LEN),
        .BUF_AW    (BUF_AW)
    ) dut (
        .clk               (clk),
        .reset_n           (reset_n),
        .start             (start),
        .base_addr         (base_addr),
        .num_words         (num_words),
        .avm_address       (avm_address),
        .avm_read          (avm_read),
        .avm_burstcount    (avm_burstcount),
        .avm_waitrequest   (avm_waitrequest),
        .avm_readdata      (avm_readdata),
        .avm_readdatavalid (avm_readdatavalid),
        .buf_wr_en         (buf_wr_en),
        .buf_wr_addr       (buf_wr_addr),
        .buf_wr_data       (buf_wr_data),
        .busy              (busy),
        .done              (done)
`ifdef INBUF_LOADER_STATS_EN
        ,
        .stall_cycles      (stall_cycles),
        .xfer_cycles       (xfer_cycles)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [6:0]  c;
    } burst_t;

    typedef struct {
        logic [BUF_AW-1:0] a;
        logic [DATA_W-1:0] d;
    } wr_t;

    typedef struct {
        logic [31:0] base;
        logic [10:0] num;
        int          stall;
        bit          mid_start;
        int          exp_bursts;
        int          exp_writes;
        logic [6:0]  exp_first_bc;
    } vec_t;

    burst_t bq[$];
    wr_t    wq[$];
    vec_t   vecs[8];

    int n_cmp = 0;
    int n_fail = 0;
    int writes_seen;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mem_word(input logic [31:0] a);
        logic [DATA_W-1:0] w;
        for (int k = 0; k < 8; k++)
            w[k*32 +: 32] = {a[23:0], 8'(k)} ^ 32'h5A0F_C3E1;
        return w;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_write();
        wr_t e;
        if (buf_wr_en) begin
            writes_seen++;
            if (wq.size() == 0) begin
                chk("write_unexpected", 256'(buf_wr_en), 256'(0));
            end else begin
                e = wq.pop_front();
                chk("wr_addr", 256'(buf_wr_addr), 256'(e.a));
                chk("wr_data", 256'(buf_wr_data), 256'(e.d));
            end
        end
    endtask

    task automatic run_xfer(input vec_t v);
        burst_t      b;
        wr_t         w;
        logic [31:0] a;
        int          rem;
        int          bc;
        int          done_cnt;
        int          bursts_seen;
        int          pending;
        int          stall_left;
        int          cyc;
        logic [31:0] beat_addr;
        logic [31:0] req_addr;
        logic [6:0]  req_bc;
        bit          in_req;
        bit          first;
        bit          finished;

        // reference model: burst list and buffer contents for this request
        rem = (v.num > 11'd1024) ? 1024 : int'(v.num);
        a = v.base;
        while (rem > 0) begin
            bc = (rem < BURST_LEN) ? rem : BURST_LEN;
            b.a = a;
            b.c = 7'(bc);
            bq.push_back(b);
            a = a + 32'(bc);
            rem = rem - bc;
        end
        rem = (v.num > 11'd1024) ? 1024 : int'(v.num);
        for (int i = 0; i < rem; i++) begin
            w.a = BUF_AW'(i);
            w.d = mem_word(v.base + 32'(i));
            wq.push_back(w);
        end

        writes_seen = 0;
        done_cnt = 0;
        bursts_seen = 0;
        pending = 0;
        stall_left = 0;
        cyc = 0;
        beat_addr = '0;
        req_addr = '0;
        req_bc = '0;
        in_req = 1'b0;
        first = 1'b1;
        finished = 1'b0;

        base_addr = v.base;
        num_words = v.num;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("busy_after_start", 256'(busy), 256'(v.num != 11'd0));

        while (!finished && cyc < 3000) begin
            check_write();
            if (done) begin
                done_cnt++;
                chk("busy_at_done", 256'(busy), 256'(0));
                finished = 1'b1;
            end
            if (v.mid_start && cyc == 4) begin
                start = 1'b1;
                base_addr = 32'h0000_5550;
                num_words = 11'd7;
            end else begin
                start = 1'b0;
            end
            if (avm_read) begin
                avm_readdatavalid = 1'b0;
                if (!in_req) begin
                    in_req = 1'b1;
                    bursts_seen++;
                    req_addr = avm_address;
                    req_bc = avm_burstcount;
                    stall_left = first ? v.stall : 0;
                    if (bq.size() == 0) begin
                        chk("read_unexpected", 256'(avm_read), 256'(0));
                    end else begin
                        b = bq.pop_front();
                        chk("burst_addr", 256'(avm_address), 256'(b.a));
                        chk("burst_count", 256'(avm_burstcount), 256'(b.c));
                    end
                    if (first)
                        chk("first_burstcount", 256'(avm_burstcount), 256'(v.exp_first_bc));
                    first = 1'b0;
                end else begin
                    chk("addr_stable", 256'(avm_address), 256'(req_addr));
                    chk("bc_stable", 256'(avm_burstcount), 256'(req_bc));
                end
                if (stall_left > 0) begin
                    avm_waitrequest = 1'b1;
                    stall_left--;
                end else begin
                    avm_waitrequest = 1'b0;
                    in_req = 1'b0;
                    pending = int'(req_bc);
                    beat_addr = req_addr;
                end
            end else begin
                avm_waitrequest = 1'b0;
                if (pending > 0) begin
                    avm_readdatavalid = 1'b1;
                    avm_readdata = mem_word(beat_addr);
                    beat_addr = beat_addr + 32'd1;
                    pending--;
                end else begin
                    avm_readdatavalid = 1'b0;
                end
            end
            if (!finished) begin
                step();
                cyc++;
            end
        end
        if (!finished)
            chk("done_timeout", 256'(done), 256'(1));

        start = 1'b0;
        avm_readdatavalid = 1'b0;
        avm_waitrequest = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            check_write();
            chk("done_single_pulse", 256'(done), 256'(0));
            chk("read_after_done", 256'(avm_read), 256'(0));
        end
        chk("done_count", 256'(done_cnt), 256'(1));
        chk("n_bursts", 256'(bursts_seen), 256'(v.exp_bursts));
        chk("n_writes", 256'(writes_seen), 256'(v.exp_writes));
        chk("writes_missing", 256'(wq.size()), 256'(0));
`ifdef INBUF_LOADER_STATS_EN
        chk("stall_cycles", 256'(stall_cycles), 256'(v.stall));
`endif
        bq.delete();
        wq.delete();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //          base           num     stall mid  bursts writes first_bc
        vecs[0] = '{32'h0000_0100, 11'd40,   0,  1'b0,  3,   40,   7'd16};
        vecs[1] = '{32'h0000_0000, 11'd0,    0,  1'b0,  0,    0,   7'd0};
        vecs[2] = '{32'h0000_2000, 11'd20,   5,  1'b0,  2,   20,   7'd16};
        vecs[3] = '{32'hFFFF_FFFF, 11'd1,    0,  1'b0,  1,    1,   7'd1};
        vecs[4] = '{32'hFFFF_FFF8, 11'd20,   0,  1'b0,  2,   20,   7'd16};
        vecs[5] = '{32'h0001_0000, 11'd2047, 0,  1'b0, 64, 1024,   7'd16};
        vecs[6] = '{32'h0000_0300, 11'd5,    0,  1'b1,  1,    5,   7'd5};
        vecs[7] = '{32'h0000_0040, 11'd17,   2,  1'b0,  2,   17,   7'd16};

        reset_n = 1'b0;
        start = 1'b0;
        base_addr = '0;
        num_words = '0;
        avm_waitrequest = 1'b0;
        avm_readdata = '0;
        avm_readdatavalid = 1'b0;
        step();
        step();
        chk("rst_avm_read", 256'(avm_read), 256'(0));
        chk("rst_avm_address", 256'(avm_address), 256'(0));
        chk("rst_burstcount", 256'(avm_burstcount), 256'(0));
        chk("rst_buf_wr_en", 256'(buf_wr_en), 256'(0));
        chk("rst_buf_wr_addr", 256'(buf_wr_addr), 256'(0));
        chk("rst_buf_wr_data", 256'(buf_wr_data), 256'(0));
        chk("rst_busy", 256'(busy), 256'(0));
        chk("rst_done", 256'(done), 256'(0));
        reset_n = 1'b1;
        step();

        for (int i = 0; i < 8; i++)
            run_xfer(vecs[i]);

        // start during the FINISH cycle is ignored
        base_addr = 32'h0000_0900;
        num_words = 11'd0;
        start = 1'b1;
        step();
        chk("fin_done", 256'(done), 256'(1));
        num_words = 11'd3;
        step();
        start = 1'b0;
        chk("fin_done_cleared", 256'(done), 256'(0));
        chk("fin_start_ignored_busy", 256'(busy), 256'(0));
        chk("fin_start_ignored_read", 256'(avm_read), 256'(0));
        step();
        chk("fin_still_idle_read", 256'(avm_read), 256'(0));
        chk("fin_still_idle_busy", 256'(busy), 256'(0));

        // reset after 3 beats of a 16-beat burst, then the rest of the beats arrive
        base_addr = 32'h0000_0400;
        num_words = 11'd32;
        start = 1'b1;
        step();
        start = 1'b0;
        chk("rb_read", 256'(avm_read), 256'(1));
        chk("rb_addr", 256'(avm_address), 256'(32'h400));
        chk("rb_bc", 256'(avm_burstcount), 256'(16));
        avm_waitrequest = 1'b0;
        step();
        for (int i = 0; i < 3; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem_word(32'h400 + 32'(i));
            step();
            chk("rb_pre_wr_en", 256'(buf_wr_en), 256'(1));
            chk("rb_pre_wr_addr", 256'(buf_wr_addr), 256'(i));
            chk("rb_pre_wr_data", 256'(buf_wr_data), 256'(mem_word(32'h400 + 32'(i))));
        end
        avm_readdatavalid = 1'b0;
        reset_n = 1'b0;
        step();
        reset_n = 1'b1;
        chk("rb_busy_after_rst", 256'(busy), 256'(0));
        chk("rb_read_after_rst", 256'(avm_read), 256'(0));
        chk("rb_wr_en_after_rst", 256'(buf_wr_en), 256'(0));
        chk("rb_done_after_rst", 256'(done), 256'(0));
        for (int i = 3; i < 16; i++) begin
            avm_readdatavalid = 1'b1;
            avm_readdata = mem_word(32'h400 + 32'(i));
            step();
            chk("rb_dropped_wr_en", 256'(buf_wr_en), 256'(0));
            chk("rb_no_done", 256'(done), 256'(0));
            chk("rb_no_read", 256'(avm_read), 256'(0));
        end
        avm_readdatavalid = 1'b0;
        step();
        chk("rb_final_busy", 256'(busy), 256'(0));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
